// File: rtl/fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and instruction memory (slave).
interface fetch_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   req;
  logic [PC_WIDTH-1:0]    addr;
  logic [INSTR_WIDTH-1:0] rdata;
  logic                   valid;

  modport master (output req, output addr, input rdata, input valid);
  modport slave  (input req, input addr, output rdata, output valid);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry hold buffer and jump redirect/flush.
// Optional FETCH_PERF_EN adds saturating fetch and bubble counters as output ports.
module fetch_stage #(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}}
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_stall,
  input  logic                   i_jump,
  input  logic [PC_WIDTH-1:0]    i_jump_target,
  fetch_if.master                imem,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [3:0]             o_opcode,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [PC_WIDTH-1:0]    o_pc_plus1
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]            o_fetch_cnt,
  output logic [15:0]            o_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0]    PC_ONE     = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PC_WIDTH-1:0]    PC_ZERO    = {PC_WIDTH{1'b0}};
  localparam logic [INSTR_WIDTH-1:0] INSTR_ZERO = {INSTR_WIDTH{1'b0}};

  state_t                 state_r, state_n;
  logic [PC_WIDTH-1:0]    pc_r, pc_n;
  logic [PC_WIDTH-1:0]    addr_r, addr_n;
  logic                   req_r, req_n;
  logic                   discard_r, discard_n;
  logic                   valid_r, valid_n;
  logic [INSTR_WIDTH-1:0] instr_r, instr_n;
  logic [PC_WIDTH-1:0]    opc_r, opc_n;
  logic [PC_WIDTH-1:0]    pc_plus1_r, pc_plus1_n;
  logic [INSTR_WIDTH-1:0] hold_instr_r, hold_instr_n;
  logic [PC_WIDTH-1:0]    hold_pc_r, hold_pc_n;
  logic                   req_s;
  logic                   resp_s;
  logic                   jump_s;

  assign req_s  = (state_r == S_REQ);
  assign resp_s = req_s & imem.valid;
  assign jump_s = i_jump & valid_r;

  // Next-state, PC, IF/ID and hold-buffer update; a live jump overrides everything.
  always_comb begin
    state_n      = state_r;
    pc_n         = pc_r;
    discard_n    = discard_r;
    valid_n      = valid_r;
    instr_n      = instr_r;
    opc_n        = opc_r;
    pc_plus1_n   = pc_plus1_r;
    hold_instr_n = hold_instr_r;
    hold_pc_n    = hold_pc_r;
    if (jump_s) begin
      pc_n         = i_jump_target;
      valid_n      = 1'b0;
      hold_instr_n = INSTR_ZERO;
      hold_pc_n    = PC_ZERO;
      state_n      = S_REQ;
      // A response already in flight for the old path must be swallowed later.
      discard_n    = req_s & ~imem.valid;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_n = S_REQ;
        end
        S_REQ: begin
          if (resp_s) begin
            if (discard_r) begin
              discard_n = 1'b0;
              if (valid_r & ~i_stall) begin
                valid_n = 1'b0;
              end else begin
                valid_n = valid_r;
              end
            end else if (~valid_r | ~i_stall) begin
              instr_n    = imem.rdata;
              opc_n      = pc_r;
              pc_plus1_n = pc_r + PC_ONE;
              valid_n    = 1'b1;
              pc_n       = pc_r + PC_ONE;
            end else begin
              hold_instr_n = imem.rdata;
              hold_pc_n    = pc_r;
              pc_n         = pc_r + PC_ONE;
              state_n      = S_HOLD;
            end
          end else if (valid_r & ~i_stall) begin
            valid_n = 1'b0;
          end else begin
            valid_n = valid_r;
          end
        end
        S_HOLD: begin
          if (~i_stall) begin
            instr_n    = hold_instr_r;
            opc_n      = hold_pc_r;
            pc_plus1_n = hold_pc_r + PC_ONE;
            valid_n    = 1'b1;
            state_n    = S_REQ;
          end else begin
            state_n = S_HOLD;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
    // While a stale response is pending the bus keeps showing the old address.
    addr_n = discard_n ? addr_r : pc_n;
    req_n  = (state_n == S_REQ);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= S_IDLE;
      pc_r         <= RESET_PC;
      addr_r       <= RESET_PC;
      req_r        <= 1'b0;
      discard_r    <= 1'b0;
      valid_r      <= 1'b0;
      instr_r      <= INSTR_ZERO;
      opc_r        <= PC_ZERO;
      pc_plus1_r   <= PC_ONE;
      hold_instr_r <= INSTR_ZERO;
      hold_pc_r    <= PC_ZERO;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      addr_r       <= addr_n;
      req_r        <= req_n;
      discard_r    <= discard_n;
      valid_r      <= valid_n;
      instr_r      <= instr_n;
      opc_r        <= opc_n;
      pc_plus1_r   <= pc_plus1_n;
      hold_instr_r <= hold_instr_n;
      hold_pc_r    <= hold_pc_n;
    end
  end

  assign imem.req   = req_r;
  assign imem.addr  = addr_r;
  assign o_valid    = valid_r;
  assign o_instr    = instr_r;
  assign o_opcode   = instr_r[INSTR_WIDTH-1 -: 4];
  assign o_pc       = opc_r;
  assign o_pc_plus1 = pc_plus1_r;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_r;
  logic [15:0] bubble_cnt_r;
  logic        fetch_inc_s;
  logic        bubble_inc_s;

  assign fetch_inc_s  = resp_s & ~discard_r & ~jump_s;
  assign bubble_inc_s = (state_r != S_IDLE) & ~valid_r;

  // Saturating counters of accepted responses and empty IF/ID cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_cnt_r  <= 16'd0;
      bubble_cnt_r <= 16'd0;
    end else begin
      if (fetch_inc_s && (fetch_cnt_r != 16'hFFFF)) begin
        fetch_cnt_r <= fetch_cnt_r + 16'd1;
      end
      if (bubble_inc_s && (bubble_cnt_r != 16'hFFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 16'd1;
      end
    end
  end

  assign o_fetch_cnt  = fetch_cnt_r;
  assign o_bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stall/hold, jump flush, stale-response discard, PC wrap.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, stall, jump;
  logic [7:0] jtarget;
  logic       valid;
  logic [15:0] instr;
  logic [3:0] opcode;
  logic [7:0] opc, pcp1;

  logic       rst_nb, stall_b, jump_b;
  logic [7:0] jtarget_b;
  logic       valid_b;
  logic [15:0] instr_b;
  logic [3:0] opcode_b;
  logic [7:0] opc_b, pcp1_b;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;
  int cnt      = 0;
  logic [7:0] exp_q[$];

`ifdef FETCH_PERF_EN
  logic [15:0] fcnt, bcnt, fcnt_b, bcnt_b;
`endif

  function automatic logic [15:0] rom(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  fetch_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();
  fetch_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) busb ();

  // Memory A: response after `lat` request cycles (lat=1 is a 0-wait ROM).
  always @(posedge clk) begin
    if (bus.req && !bus.valid) cnt <= cnt + 1;
    else cnt <= 0;
  end
  assign bus.valid  = bus.req && (cnt == lat - 1);
  assign bus.rdata  = rom(bus.addr);
  assign busb.valid = busb.req;
  assign busb.rdata = rom(busb.addr);

  fetch_stage #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_jump(jump), .i_jump_target(jtarget),
    .imem(bus), .o_valid(valid), .o_instr(instr), .o_opcode(opcode), .o_pc(opc), .o_pc_plus1(pcp1)
`ifdef FETCH_PERF_EN
    , .o_fetch_cnt(fcnt), .o_bubble_cnt(bcnt)
`endif
  );

  fetch_stage #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'hFE)) dut_b (
    .i_clk(clk), .i_rst_n(rst_nb), .i_stall(stall_b), .i_jump(jump_b), .i_jump_target(jtarget_b),
    .imem(busb), .o_valid(valid_b), .o_instr(instr_b), .o_opcode(opcode_b), .o_pc(opc_b), .o_pc_plus1(pcp1_b)
`ifdef FETCH_PERF_EN
    , .o_fetch_cnt(fcnt_b), .o_bubble_cnt(bcnt_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every instruction consumed by ID is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && valid && (!stall || jump)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra actual_pc=%0h required=none", opc);
        end else begin
          logic [7:0]  e;
          logic [7:0]  e1;
          logic [15:0] w;
          e  = exp_q.pop_front();
          e1 = e + 8'd1;
          w  = rom(e);
          chk("sb_pc", {24'd0, opc}, {24'd0, e});
          chk("sb_instr", {16'd0, instr}, {16'd0, w});
          chk("sb_opcode", {28'd0, opcode}, {28'd0, w[15:12]});
          chk("sb_pc_plus1", {24'd0, pcp1}, {24'd0, e1});
        end
      end
    end
  end

  initial begin
    logic [7:0] seq [10];
    seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h40, 8'h06, 8'h20, 8'h21};
    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; jtarget = 8'h00;
    rst_nb = 1'b0; stall_b = 1'b0; jump_b = 1'b0; jtarget_b = 8'h00;
    foreach (seq[i]) exp_q.push_back(seq[i]);

    tick(2);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", opc, 0);
    chk("rst_req", bus.req, 0);
    chk("rst_addr", bus.addr, 8'h00);
`ifdef FETCH_PERF_EN
    chk("rst_fcnt", fcnt, 0);
    chk("rst_bcnt", bcnt, 0);
`endif

    // 0-wait straight line
    rst_n = 1'b1;
    tick(1);
    chk("t1_req", bus.req, 1);
    chk("t1_addr0", bus.addr, 8'h00);
    chk("t1_valid0", valid, 0);
    tick(1);
    chk("t1_addr1", bus.addr, 8'h01);
    chk("t1_valid1", valid, 1);
    tick(1);
    chk("t1_addr2", bus.addr, 8'h02);
    tick(1);
    chk("t1_addr3", bus.addr, 8'h03);
    chk("t1_pc2", opc, 8'h02);

    // stall three cycles with o_pc=2
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("t2_frozen_pc", opc, 8'h02);
      chk("t2_frozen_instr", instr, rom(8'h02));
      chk("t2_hold_req", bus.req, 0);
    end
    stall = 1'b0;
    tick(1);
    chk("t2_pc3", opc, 8'h03);
    chk("t2_addr4", bus.addr, 8'h04);
    tick(2);
    chk("t2_pc5", opc, 8'h05);
`ifdef FETCH_PERF_EN
    chk("t6_fcnt_pre", fcnt, 6);
    chk("t6_bcnt_pre", bcnt, 1);
`endif

    // jump at o_pc=5 to 0x40
    jump = 1'b1; jtarget = 8'h40;
    tick(1);
    jump = 1'b0;
    chk("t3_flush", valid, 0);
    chk("t3_addr40", bus.addr, 8'h40);
    chk("t3_req", bus.req, 1);
`ifdef FETCH_PERF_EN
    chk("t6_fcnt_flush", fcnt, 6);
`endif
    tick(1);
    chk("t3_pc40", opc, 8'h40);
    chk("t3_valid", valid, 1);
`ifdef FETCH_PERF_EN
    chk("t6_fcnt_post", fcnt, 7);
    chk("t6_bcnt_post", bcnt, 2);
`endif

    // jump to 6, then switch to a 3-cycle memory
    jump = 1'b1; jtarget = 8'h06;
    tick(1);
    jump = 1'b0;
    lat = 3;
    chk("t4_addr6", bus.addr, 8'h06);
    tick(3);
    chk("t4_pc6", opc, 8'h06);
    chk("t4_addr7", bus.addr, 8'h07);

    // jump to 0x20 while addr 7 is outstanding
    jump = 1'b1; jtarget = 8'h20;
    tick(1);
    jump = 1'b0;
    chk("t4_flush", valid, 0);
    chk("t4_stale_addr_a", bus.addr, 8'h07);
    tick(1);
    chk("t4_stale_addr_b", bus.addr, 8'h07);
    tick(1);
    chk("t4_addr20", bus.addr, 8'h20);
    chk("t4_still_empty", valid, 0);
    tick(3);
    chk("t4_pc20", opc, 8'h20);
    chk("t4_valid", valid, 1);
`ifdef FETCH_PERF_EN
    chk("t6_fcnt_end", fcnt, 9);
    chk("t6_bcnt_end", bcnt, 10);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    tick(1);
    chk("sb_drain", exp_q.size(), 0);

    // reset mid-operation
    rst_n = 1'b0;
    tick(1);
    chk("mrst_valid", valid, 0);
    chk("mrst_pc", opc, 0);
    chk("mrst_req", bus.req, 0);
    chk("mrst_addr", bus.addr, 8'h00);
`ifdef FETCH_PERF_EN
    chk("mrst_fcnt", fcnt, 0);
`endif

    // RESET_PC=0xFE wrap
    chk("t5_rst_pc", opc_b, 8'h00);
    chk("t5_rst_addr", busb.addr, 8'hFE);
    rst_nb = 1'b1;
    tick(1);
    chk("t5_req", busb.req, 1);
    tick(1);
    chk("t5_pcFE", opc_b, 8'hFE);
    chk("t5_p1FE", pcp1_b, 8'hFF);
    chk("t5_instrFE", instr_b, 16'hA4FE);
    tick(1);
    chk("t5_pcFF", opc_b, 8'hFF);
    chk("t5_p1FF", pcp1_b, 8'h00);
    chk("t5_addr00", busb.addr, 8'h00);
    tick(1);
    chk("t5_pc00", opc_b, 8'h00);
    chk("t5_p100", pcp1_b, 8'h01);
    chk("t5_opc00", opcode_b, 4'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
